qr_col_div_sched: RTL and testbench
===================================

Name: qr_col_div_sched

Overview:
- Column scheduler for the QR normalisation stage (e = h / Rii, 4x4 complex channel).
- Fetches each of NUM_COL columns from the H column buffer, obtains Rii from the norm unit, then drives the 8-lane pipelined divider bank and collects e.
- Emits each normalised column with its index and Rii.
- Owns the divider-bank enable: operands are held stable and the enable stays high until the divider reports valid.

Parameters:
- NUM_COL, 4, columns per matrix; column index width is clog2(NUM_COL).
- DIV_LAT, 2, cycles from the first o_div_en to i_e_valid.
- TO_MARGIN, 2, extra cycles tolerated beyond DIV_LAT before timeout.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  start pulse for one matrix; ignored while o_busy
- o_col_rd  out  1  column read strobe, one cycle
- o_col_idx  out  2  column read address
- i_col_data  in  192  column {im3,re3,...,im0,re0}, 24b lanes, valid one cycle after o_col_rd
- o_norm_req  out  1  norm request, level, held until i_norm_valid
- o_norm_col  out  192  column to norm unit, stable while o_norm_req
- i_norm_valid  in  1  Rii valid, variable latency
- i_norm_rii  in  20  Rii, unsigned
- o_div_en  out  1  divider enable
- o_div_h  out  192  dividend column
- o_div_rii  out  20  divisor
- i_e  in  192  divider result, 24b lanes
- i_e_valid  in  1  divider result valid
- o_e_valid  out  1  result strobe, one cycle
- o_e  out  192  normalised column
- o_e_idx  out  2  column index of o_e
- o_rii  out  20  Rii of o_e
- o_busy  out  1  high from accepted start until o_done
- o_done  out  1  one-cycle pulse after last column
- o_err  out  2  sticky: bit0 Rii==0 seen, bit1 divider timeout; cleared on accepted start

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; column counter 0.
- IDLE: i_start=1 -> clear o_err, counter=0, o_busy=1 -> RD.
- RD: o_col_rd=1, o_col_idx=counter, for one cycle -> CAP.
- CAP: latch i_col_data into the column register -> NORM.
- NORM: o_norm_req=1 with o_norm_col=column register.
  - On i_norm_valid: latch Rii and drop o_norm_req in the same cycle.
  - Rii==0: set o_err[0] and force e=0; skip the divider -> OUT.
  - Otherwise -> DIV.
- DIV: o_div_en=1; o_div_h and o_div_rii are held constant. A wait counter starts at 1 on the first enable cycle.
  - On i_e_valid: latch i_e and drop o_div_en the same cycle -> OUT.
  - If the counter reaches DIV_LAT+TO_MARGIN without i_e_valid: set o_err[1], drop o_div_en, force e=0 -> OUT.
  - i_e_valid arriving outside DIV is ignored.
- OUT: o_e_valid=1 for one cycle with o_e, o_e_idx=counter, o_rii.
  - counter==NUM_COL-1 -> DONE.
  - Otherwise increment counter -> RD.
- DONE: o_done=1 and o_busy=0 in this cycle -> IDLE. A new start is accepted the following cycle.
- Outputs o_col_rd, o_norm_req, o_div_en, o_e_valid and o_done are registered (driven from state flops, no combinational path from inputs).
- Per-column latency with normal divider = 1 (RD) + 1 (CAP) + N_norm + DIV_LAT + 1 (OUT) cycles. N_norm = cycles of o_norm_req up to and including i_norm_valid.
- Columns are processed strictly in order 0..NUM_COL-1; one column in flight.
- i_start while busy: no effect; o_err is not cleared.
- Simultaneous i_norm_valid and timeout: not applicable (different states). In DIV, i_e_valid on the timeout cycle counts as success; no error.
- Reset mid-operation: everything returns to IDLE with reset values. A partially processed column is discarded; no o_done.

Test Plan:
- Nominal: norm valid 3 cycles after req, divider valid 2 cycles after first enable, columns with re0=24'h000100 and Rii=20'h00100 -> four o_e_valid pulses, o_e_idx 0,1,2,3, lane0 of o_e = i_e lane0, o_done exactly 1 cycle after the 4th strobe, o_err=0.
- Stable operands: check o_div_h and o_div_rii constant while o_div_en=1; o_div_en high for exactly 2 cycles per column.
- Rii zero on column 2 -> no o_div_en for column 2, o_e=0 with o_e_idx=2, o_err=2'b01 after done, columns 0, 1 and 3 normal.
- Divider never returns valid on column 1 -> o_div_en drops after 4 cycles, o_e=0, o_err[1]=1; column 2 still fetched.
- i_start pulsed mid-matrix ignored and o_err unchanged; new start after o_done clears o_err and restarts at idx 0.
- i_rst asserted during DIV of column 1 -> all outputs 0 within reset; a subsequent start produces idx 0 first.

Source files
------------

// File: rtl/qr_col_div_sched.sv
// Column scheduler for QR normalisation (e = h / Rii).
// Walks the columns of one matrix in order: fetch column, obtain Rii from the
// norm unit, run the divider bank with stable operands, emit the result.
// A zero Rii or a divider that never answers yields e = 0 and a sticky error.
module qr_col_div_sched #(
  parameter int NUM_COL   = 4,
  parameter int DIV_LAT   = 2,
  parameter int TO_MARGIN = 2,
  localparam int IW       = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_col_rd,
  output logic [IW-1:0] o_col_idx,
  input  logic [191:0]  i_col_data,
  output logic          o_norm_req,
  output logic [191:0]  o_norm_col,
  input  logic          i_norm_valid,
  input  logic [19:0]   i_norm_rii,
  output logic          o_div_en,
  output logic [191:0]  o_div_h,
  output logic [19:0]   o_div_rii,
  input  logic [191:0]  i_e,
  input  logic          i_e_valid,
  output logic          o_e_valid,
  output logic [191:0]  o_e,
  output logic [IW-1:0] o_e_idx,
  output logic [19:0]   o_rii,
  output logic          o_busy,
  output logic          o_done,
  output logic [1:0]    o_err
);

  // Divider wait limit; the counter reads 1 on the first enable cycle.
  localparam int TO = DIV_LAT + TO_MARGIN;
  localparam int CW = $clog2(TO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CAP, S_NORM, S_DIV, S_OUT, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_cnt;
  logic [CW-1:0]   r_wait;
  logic [191:0]    r_col;
  logic [19:0]     r_rii;
  logic [191:0]    r_e;
  logic [1:0]      r_err;
  logic            w_last_col;
  logic            w_timeout;

  assign w_last_col = (r_cnt == IW'(NUM_COL - 1));
  assign w_timeout  = (r_wait == CW'(TO));

  // State register.
  // NOTE: all clocked state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  // NOTE: w_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_RD;
      S_RD:   w_next = S_CAP;
      S_CAP:  w_next = S_NORM;
      S_NORM: if (i_norm_valid) w_next = (i_norm_rii == '0) ? S_OUT : S_DIV;
      S_DIV:  if (i_e_valid || w_timeout) w_next = S_OUT;
      S_OUT:  w_next = w_last_col ? S_DONE : S_RD;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: column counter, operand/result registers, wait counter, errors.
  // NOTE: the wide data registers are reset as well, because every output
  // they drive must read 0 during reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_wait <= '0;
      r_col  <= '0;
      r_rii  <= '0;
      r_e    <= '0;
      r_err  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_err <= '0;
            r_cnt <= '0;
          end
        end
        S_CAP: r_col <= i_col_data;
        S_NORM: begin
          r_wait <= CW'(1);
          if (i_norm_valid) begin
            r_rii <= i_norm_rii;
            if (i_norm_rii == '0) begin
              r_err[0] <= 1'b1;
              r_e      <= '0;
            end
          end
        end
        S_DIV: begin
          r_wait <= r_wait + CW'(1);
          // A result on the timeout cycle still counts as success.
          if (i_e_valid) begin
            r_e <= i_e;
          end else if (w_timeout) begin
            r_err[1] <= 1'b1;
            r_e      <= '0;
          end
        end
        S_OUT: if (!w_last_col) r_cnt <= r_cnt + IW'(1);
        default: ;
      endcase
    end
  end

  // Strobes decode straight from the state flops: no input-to-output path.
  assign o_col_rd   = (r_state == S_RD);
  assign o_norm_req = (r_state == S_NORM);
  assign o_div_en   = (r_state == S_DIV);
  assign o_e_valid  = (r_state == S_OUT);
  assign o_done     = (r_state == S_DONE);
  assign o_busy     = (r_state != S_IDLE) && (r_state != S_DONE);

  assign o_col_idx  = r_cnt;
  assign o_norm_col = r_col;
  assign o_div_h    = r_col;
  assign o_div_rii  = r_rii;
  assign o_e        = r_e;
  assign o_e_idx    = r_cnt;
  assign o_rii      = r_rii;
  assign o_err      = r_err;

endmodule

// File: tb/tb_qr_col_div_sched.sv
// Bench for qr_col_div_sched: behavioural column buffer, norm unit and
// divider responders, a reference model queueing expected results per
// column, and a monitor that checks every strobe against that queue.
module tb_qr_col_div_sched;

  localparam int NUM_COL   = 4;
  localparam int DIV_LAT   = 2;
  localparam int TO_MARGIN = 2;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_start = 1'b0;
  logic         o_col_rd;
  logic [1:0]   o_col_idx;
  logic [191:0] i_col_data = '0;
  logic         o_norm_req;
  logic [191:0] o_norm_col;
  logic         i_norm_valid = 1'b0;
  logic [19:0]  i_norm_rii = '0;
  logic         o_div_en;
  logic [191:0] o_div_h;
  logic [19:0]  o_div_rii;
  logic [191:0] i_e = '0;
  logic         i_e_valid = 1'b0;
  logic         o_e_valid;
  logic [191:0] o_e;
  logic [1:0]   o_e_idx;
  logic [19:0]  o_rii;
  logic         o_busy;
  logic         o_done;
  logic [1:0]   o_err;

  qr_col_div_sched #(.NUM_COL(NUM_COL), .DIV_LAT(DIV_LAT), .TO_MARGIN(TO_MARGIN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .o_col_rd(o_col_rd), .o_col_idx(o_col_idx), .i_col_data(i_col_data),
    .o_norm_req(o_norm_req), .o_norm_col(o_norm_col),
    .i_norm_valid(i_norm_valid), .i_norm_rii(i_norm_rii),
    .o_div_en(o_div_en), .o_div_h(o_div_h), .o_div_rii(o_div_rii),
    .i_e(i_e), .i_e_valid(i_e_valid),
    .o_e_valid(o_e_valid), .o_e(o_e), .o_e_idx(o_e_idx), .o_rii(o_rii),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [191:0] e;
    logic [1:0]   idx;
    logic [19:0]  rii;
    int           en_cycles;
  } exp_t;

  exp_t         exp_q[$];
  logic [1:0]   exp_err_q[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;

  // Per-matrix environment configuration.
  logic [191:0] col_mem [NUM_COL];
  logic [19:0]  rii_tab [NUM_COL];
  int           norm_lat[NUM_COL];
  bit           div_hang[NUM_COL];

  function automatic logic [191:0] lanes_div(input logic [191:0] h, input logic [19:0] d);
    logic [191:0] r;
    for (int l = 0; l < 8; l++) r[l*24 +: 24] = h[l*24 +: 24] / {4'b0, d};
    return r;
  endfunction

  function automatic logic [191:0] rand192();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Environment responders: column buffer, norm unit, divider bank.
  int rd_prev = 0, rd_idx = 0, cur_col = 0, ncnt = 0, dcnt = 0;
  always @(negedge i_clk) begin
    i_col_data = (rd_prev != 0) ? col_mem[rd_idx] : rand192();
    rd_prev = int'(o_col_rd);
    if (o_col_rd) begin
      rd_idx  = int'(o_col_idx);
      cur_col = int'(o_col_idx);
    end
    if (o_norm_req) begin
      ncnt++;
      i_norm_valid = (ncnt == norm_lat[cur_col]);
      i_norm_rii   = i_norm_valid ? rii_tab[cur_col] : 20'($urandom());
    end else begin
      ncnt = 0;
      i_norm_valid = 1'b0;
      i_norm_rii   = 20'($urandom());
    end
    if (o_div_en) begin
      dcnt++;
      i_e_valid = (dcnt == DIV_LAT) && !div_hang[cur_col];
      i_e       = i_e_valid ? lanes_div(o_div_h, o_div_rii) : rand192();
    end else begin
      dcnt = 0;
      i_e_valid = ($urandom_range(0, 7) == 0);  // stray pulses must be ignored
      i_e       = rand192();
    end
  end

  // Monitor: operand stability and scoreboard comparison on each strobe.
  int mon_col = 0, en_cyc = 0, last_ev = -100;
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_col_rd) begin
        mon_col = int'(o_col_idx);
        en_cyc  = 0;
      end
      if (o_norm_req) check("norm_col", o_norm_col, col_mem[mon_col]);
      if (o_div_en) begin
        en_cyc++;
        check("div_h", o_div_h, col_mem[mon_col]);
        check("div_rii", 192'(o_div_rii), 192'(rii_tab[mon_col]));
      end
      if (o_e_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_e_valid", 192'(1), 192'(0));
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          check("e_idx", 192'(o_e_idx), 192'(x.idx));
          check("e", o_e, x.e);
          check("rii", 192'(o_rii), 192'(x.rii));
          check("div_en_cycles", 192'(en_cyc), 192'(x.en_cycles));
          check("busy_at_strobe", 192'(o_busy), 192'(1));
        end
        last_ev = cyc;
      end
      if (o_done) begin
        check("done_gap", 192'(cyc - last_ev), 192'(1));
        check("busy_at_done", 192'(o_busy), 192'(0));
        if (exp_err_q.size() == 0) check("unexpected_done", 192'(1), 192'(0));
        else check("err", 192'(o_err), 192'(exp_err_q.pop_front()));
      end
    end
  end

  // Build one matrix and queue what the specification says must come out.
  task automatic setup(input int zero_col, input int hang_col, input bit nominal);
    logic [1:0] err = 2'b00;
    exp_t x;
    for (int c = 0; c < NUM_COL; c++) begin
      col_mem[c]  = rand192();
      rii_tab[c]  = 20'($urandom_range(1, 4095));
      norm_lat[c] = $urandom_range(1, 4);
      div_hang[c] = 1'b0;
      if (nominal) begin
        col_mem[c][23:0] = 24'h000100;
        rii_tab[c]       = 20'h00100;
        norm_lat[c]      = 3;
      end
      if (c == zero_col) rii_tab[c] = '0;
      if (c == hang_col) div_hang[c] = 1'b1;
      x.idx = 2'(c);
      x.rii = rii_tab[c];
      if (rii_tab[c] == '0) begin
        x.e = '0; x.en_cycles = 0; err[0] = 1'b1;
      end else if (div_hang[c]) begin
        x.e = '0; x.en_cycles = DIV_LAT + TO_MARGIN; err[1] = 1'b1;
      end else begin
        x.e = lanes_div(col_mem[c], rii_tab[c]); x.en_cycles = DIV_LAT;
      end
      exp_q.push_back(x);
    end
    exp_err_q.push_back(err);
  endtask

  task automatic pulse_start();
    @(negedge i_clk) i_start = 1'b1;
    @(negedge i_clk) i_start = 1'b0;
  endtask

  task automatic run_matrix(input int zero_col, input int hang_col, input bit nominal,
                            input int mid_start_at);
    bit done_seen = 1'b0;
    setup(zero_col, hang_col, nominal);
    pulse_start();
    for (int k = 0; k < 300 && !done_seen; k++) begin
      @(negedge i_clk);
      i_start = (k == mid_start_at);
      if (o_done) done_seen = 1'b1;
    end
    i_start = 1'b0;
    if (!done_seen) check("done_timeout", 192'(0), 192'(1));
    @(negedge i_clk);
  endtask

  task automatic reset_mid_div();
    bit hit = 1'b0;
    setup(-1, -1, 1'b0);
    pulse_start();
    for (int k = 0; k < 300 && !hit; k++) begin
      @(negedge i_clk);
      if (o_div_en && cur_col == 1) hit = 1'b1;
    end
    if (!hit) check("reach_div_col1", 192'(0), 192'(1));
    i_rst = 1'b1;
    #1;
    check("mid_reset_outputs", 192'(|{o_col_rd, o_col_idx, o_norm_req, o_norm_col, o_div_en,
          o_div_h, o_div_rii, o_e_valid, o_e, o_e_idx, o_rii, o_busy, o_done, o_err}), 192'(0));
    exp_q.delete();
    exp_err_q.delete();
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  initial begin
    for (int c = 0; c < NUM_COL; c++) begin
      col_mem[c] = '0; rii_tab[c] = 20'd1; norm_lat[c] = 1; div_hang[c] = 1'b0;
    end
    repeat (3) @(negedge i_clk);
    check("reset_outputs", 192'(|{o_col_rd, o_col_idx, o_norm_req, o_norm_col, o_div_en,
          o_div_h, o_div_rii, o_e_valid, o_e, o_e_idx, o_rii, o_busy, o_done, o_err}), 192'(0));
    i_rst = 1'b0;
    @(negedge i_clk);
    check("idle_not_busy", 192'(o_busy), 192'(0));

    run_matrix(-1, -1, 1'b1, -1);   // nominal
    run_matrix(2, -1, 1'b0, -1);    // Rii zero on column 2
    run_matrix(-1, 1, 1'b0, -1);    // divider hang on column 1
    run_matrix(0, -1, 1'b0, 14);    // error early, start pulse mid-matrix must not clear it
    run_matrix(-1, -1, 1'b0, 9);    // fresh start clears error; mid start ignored
    for (int m = 0; m < 6; m++) begin
      int zc, hc, ms;
      zc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      hc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      ms = ($urandom_range(0, 1) == 0) ? int'($urandom_range(3, 25)) : -1;
      run_matrix(zc, hc, 1'b0, ms);
    end
    reset_mid_div();
    run_matrix(-1, -1, 1'b0, -1);   // first strobe after reset must be idx 0

    repeat (5) @(negedge i_clk);
    check("scoreboard_empty", 192'(exp_q.size() + exp_err_q.size()), 192'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
